// File: rtl/ldl_inv_combine.sv
`default_nettype none
// ============================================================================
//  Module      : ldl_inv_combine
//  Description : Final LDL inversion stage. Forms Ainv = Linv^T * Dinv * Linv
//                in Q-format fixed point, one upper-triangle element at a
//                time, and writes each result to both (i,j) and (j,i) of the
//                result RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldl_inv_combine #(
    parameter int N     = 4,
    parameter int Q     = 24,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [$clog2(N*N)-1:0]    l_addr_a,
    output logic [$clog2(N*N)-1:0]    l_addr_b,
    input  logic [WIDTH-1:0]          l_data_a,
    input  logic [WIDTH-1:0]          l_data_b,
    output logic [$clog2(N)-1:0]      d_addr,
    input  logic [WIDTH-1:0]          d_data,
    output logic                      wr_en,
    output logic [$clog2(N*N)-1:0]    wr_addr,
    output logic [WIDTH-1:0]          wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int AW   = $clog2(N*N);
    localparam int IW   = $clog2(N);
    localparam int PW   = 2*WIDTH;
    localparam int ACCW = 2*WIDTH + $clog2(N);

    localparam logic [IW-1:0]    c_last = IW'(N-1);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1) << Q;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_ISSUE = 4'd2,
        S_WAIT  = 4'd3,
        S_MUL1  = 4'd4,
        S_MUL2  = 4'd5,
        S_WR_U  = 4'd6,
        S_WR_L  = 4'd7,
        S_NEXT  = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [IW-1:0]           r_i;
    logic [IW-1:0]           r_j;
    logic [IW-1:0]           r_k;
    logic signed [ACCW-1:0]  r_acc;
    logic [WIDTH-1:0]        r_p1;
    logic [WIDTH-1:0]        r_b;
    logic [AW-1:0]           r_addr_a;
    logic [AW-1:0]           r_addr_b;
    logic [IW-1:0]           r_d_addr;
    logic                    r_wr_en;
    logic [AW-1:0]           r_wr_addr;
    logic [WIDTH-1:0]        r_wr_data;
    logic                    r_busy;
    logic                    r_done;

    logic [IW-1:0]           w_k_nxt;
    logic                    w_load_addr;
    logic [WIDTH-1:0]        w_a_op;
    logic [WIDTH-1:0]        w_b_op;
    logic signed [PW-1:0]    w_prod1;
    logic [WIDTH-1:0]        w_p1;
    logic signed [PW-1:0]    w_prod2;
    logic [WIDTH-1:0]        w_result;

    // Row-major address of element (row, col).
    function automatic logic [AW-1:0] f_addr(input logic [IW-1:0] row,
                                             input logic [IW-1:0] col);
        return AW'(row) * AW'(N) + AW'(col);
    endfunction

    // The diagonal of Linv is implicitly 1.0, so the RAM word is never used there.
    assign w_a_op = (r_k == r_i) ? c_one : l_data_a;
    assign w_b_op = (r_k == r_j) ? c_one : l_data_b;

    assign w_prod1 = {{WIDTH{w_a_op[WIDTH-1]}}, w_a_op} * {{WIDTH{d_data[WIDTH-1]}}, d_data};
    assign w_p1    = WIDTH'(w_prod1 >>> Q);
    assign w_prod2 = {{WIDTH{r_p1[WIDTH-1]}}, r_p1} * {{WIDTH{r_b[WIDTH-1]}}, r_b};

    // Floor rounding falls out of the arithmetic shift; no saturation.
    assign w_result = WIDTH'(r_acc >>> Q);

    // k for the next read burst: starts at j, then steps by one.
    assign w_k_nxt     = (r_state == S_INIT) ? r_j : r_k + IW'(1);
    assign w_load_addr = (r_state == S_INIT) || ((r_state == S_MUL2) && (r_k != c_last));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: per-k read/multiply loop nested in the (i,j) pair walk.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_INIT;
            S_INIT:  w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_MUL1;
            S_MUL1:  w_state_nxt = S_MUL2;
            S_MUL2:  w_state_nxt = (r_k == c_last) ? S_WR_U : S_ISSUE;
            S_WR_U:  w_state_nxt = (r_i == r_j) ? S_NEXT : S_WR_L;
            S_WR_L:  w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = ((r_i == c_last) && (r_j == c_last)) ? S_DONE : S_INIT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: indices, read addresses, multiply pipeline, accumulator, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_p1      <= '0;
            r_b       <= '0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_d_addr  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            // Addresses change only on entry to ISSUE and hold otherwise.
            if (w_load_addr) begin
                r_k      <= w_k_nxt;
                r_addr_a <= f_addr(w_k_nxt, r_i);
                r_addr_b <= f_addr(w_k_nxt, r_j);
                r_d_addr <= w_k_nxt;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_i    <= '0;
                        r_j    <= '0;
                    end
                end
                S_INIT: begin
                    r_acc <= '0;
                end
                S_MUL1: begin
                    r_p1 <= w_p1;
                    r_b  <= w_b_op;
                end
                S_MUL2: begin
                    r_acc <= r_acc + {{(ACCW-PW){w_prod2[PW-1]}}, w_prod2};
                end
                S_WR_U: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= f_addr(r_i, r_j);
                    r_wr_data <= w_result;
                end
                S_WR_L: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= f_addr(r_j, r_i);
                    r_wr_data <= w_result;
                end
                S_NEXT: begin
                    if (r_j != c_last) begin
                        r_j <= r_j + IW'(1);
                    end else if (r_i != c_last) begin
                        r_i <= r_i + IW'(1);
                        r_j <= r_i + IW'(1);
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign l_addr_a = r_addr_a;
    assign l_addr_b = r_addr_b;
    assign d_addr   = r_d_addr;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ldl_inv_combine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldl_inv_combine
//  Description : Scoreboard bench for ldl_inv_combine at N=4 and N=2 with
//                behavioural RAM models and a matrix-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldl_inv_combine;

    localparam int Q   = 24;
    localparam int ONE = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    // N=4 instance signals
    logic        start4;
    logic [3:0]  l4_addr_a, l4_addr_b, wr_addr4;
    logic [31:0] l4_data_a, l4_data_b, d4_data, wr_data4;
    logic [1:0]  d4_addr;
    logic        wr_en4, busy4, done4;

    // N=2 instance signals
    logic        start2;
    logic [1:0]  l2_addr_a, l2_addr_b, wr_addr2;
    logic [31:0] l2_data_a, l2_data_b, d2_data, wr_data2;
    logic [0:0]  d2_addr;
    logic        wr_en2, busy2, done2;

    logic [31:0] lmem4 [16];
    logic [31:0] dmem4 [4];
    logic [31:0] lmem2 [4];
    logic [31:0] dmem2 [2];

    wr_t q4 [$];
    wr_t q2 [$];
    int  dq4 [$];
    int  dq2 [$];
    int  done_cnt4;
    int  done_cnt2;

    ldl_inv_combine #(.N(4), .Q(24), .WIDTH(32)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .l_addr_a(l4_addr_a), .l_addr_b(l4_addr_b),
        .l_data_a(l4_data_a), .l_data_b(l4_data_b),
        .d_addr(d4_addr), .d_data(d4_data),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .busy(busy4), .done(done4)
    );

    ldl_inv_combine #(.N(2), .Q(24), .WIDTH(32)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .l_addr_a(l2_addr_a), .l_addr_b(l2_addr_b),
        .l_data_a(l2_data_a), .l_data_b(l2_data_b),
        .d_addr(d2_addr), .d_data(d2_data),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time done relative to the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAMs, one cycle latency.
    always @(posedge clk) begin
        l4_data_a <= lmem4[l4_addr_a];
        l4_data_b <= lmem4[l4_addr_b];
        d4_data   <= dmem4[d4_addr];
        l2_data_a <= lmem2[l2_addr_a];
        l2_data_b <= lmem2[l2_addr_b];
        d2_data   <= dmem2[d2_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: one element of Linv^T * D * Linv using the fixed-point rules.
    function automatic logic [31:0] model_elem(input int n, input int r, input int c,
                                               input logic [31:0] lm [16],
                                               input logic [31:0] dm [4]);
        logic signed [127:0] acc;
        int     a, b, d, p1;
        longint prod, p2;
        acc = '0;
        for (int k = c; k < n; k++) begin
            a    = (k == r) ? ONE : int'(lm[k*n + r]);
            b    = (k == c) ? ONE : int'(lm[k*n + c]);
            d    = int'(dm[k]);
            prod = longint'(a) * longint'(d);
            p1   = int'(prod >>> Q);
            p2   = longint'(p1) * longint'(b);
            acc  = acc + p2;
        end
        return acc[Q+31:Q];
    endfunction

    task automatic build_exp(input int n);
        logic [31:0] lm [16];
        logic [31:0] dm [4];
        wr_t e;
        logic [31:0] v;
        for (int x = 0; x < 16; x++) lm[x] = '0;
        for (int x = 0; x < 4; x++)  dm[x] = '0;
        if (n == 4) begin
            for (int x = 0; x < 16; x++) lm[x] = lmem4[x];
            for (int x = 0; x < 4; x++)  dm[x] = dmem4[x];
        end else begin
            for (int x = 0; x < 4; x++)  lm[x] = lmem2[x];
            for (int x = 0; x < 2; x++)  dm[x] = dmem2[x];
        end
        for (int i = 0; i < n; i++) begin
            for (int j = i; j < n; j++) begin
                v = model_elem(n, i, j, lm, dm);
                e.addr = 32'(i*n + j); e.data = v;
                if (n == 4) q4.push_back(e); else q2.push_back(e);
                if (i != j) begin
                    e.addr = 32'(j*n + i);
                    if (n == 4) q4.push_back(e); else q2.push_back(e);
                end
            end
        end
    endtask

    task automatic push2(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 32'(addr); e.data = data;
        q2.push_back(e);
    endtask

    task automatic do_start4();
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        dq4.push_back(cyc + 117);
    endtask

    task automatic do_start2();
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        dq2.push_back(cyc + 27);
    endtask

    task automatic wait_done4(input int budget);
        int c0, n;
        c0 = done_cnt4; n = 0;
        while (done_cnt4 == c0 && n < budget) begin @(posedge clk); n++; end
        chk("done4_seen", 64'(done_cnt4 != c0), 64'd1);
        repeat (3) @(posedge clk);
        chk("writes4_remaining", 64'(q4.size()), 64'd0);
    endtask

    task automatic wait_done2(input int budget);
        int c0, n;
        c0 = done_cnt2; n = 0;
        while (done_cnt2 == c0 && n < budget) begin @(posedge clk); n++; end
        chk("done2_seen", 64'(done_cnt2 != c0), 64'd1);
        repeat (3) @(posedge clk);
        chk("writes2_remaining", 64'(q2.size()), 64'd0);
    endtask

    task automatic set_ident4(input bit garbage);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                lmem4[r*4+c] = (r > c) ? 32'h0 : (garbage ? 32'hDEAD_BEEF : ((r == c) ? ONE : 32'h0));
    endtask

    function automatic logic [31:0] rnd_val(input bit full);
        int v;
        if (full) return $urandom;
        v = int'($urandom_range(32'h0400_0000, 0)) - 32'sh0200_0000;
        return v;
    endfunction

    // Monitor for the N=4 instance.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_en4) begin
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr4_unexpected: got write addr %0d data %h, expected no write", wr_addr4, wr_data4);
                end else begin
                    e = q4.pop_front();
                    chk("wr4_addr", 64'(wr_addr4), 64'(e.addr));
                    chk("wr4_data", 64'(wr_data4), 64'(e.data));
                end
            end
            if (done4) begin
                done_cnt4++;
                chk("done4_busy_low", 64'(busy4), 64'd0);
                if (dq4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done4_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    chk("done4_cycle", 64'(cyc), 64'(dq4.pop_front()));
                end
            end
        end
    end

    // Monitor for the N=2 instance.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_en2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr2_unexpected: got write addr %0d data %h, expected no write", wr_addr2, wr_data2);
                end else begin
                    e = q2.pop_front();
                    chk("wr2_addr", 64'(wr_addr2), 64'(e.addr));
                    chk("wr2_data", 64'(wr_data2), 64'(e.data));
                end
            end
            if (done2) begin
                done_cnt2++;
                chk("done2_busy_low", 64'(busy2), 64'd0);
                if (dq2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done2_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    chk("done2_cycle", 64'(cyc), 64'(dq2.pop_front()));
                end
            end
        end
    end

    initial begin
        cyc = 0; checks = 0; errors = 0;
        done_cnt4 = 0; done_cnt2 = 0;
        rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
        set_ident4(1'b0);
        for (int x = 0; x < 4; x++) dmem4[x] = ONE;
        for (int x = 0; x < 4; x++) lmem2[x] = 32'h0;
        for (int x = 0; x < 2; x++) dmem2[x] = ONE;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   64'(wr_en4),    64'd0);
        chk("rst_done",    64'(done4),     64'd0);
        chk("rst_busy",    64'(busy4),     64'd0);
        chk("rst_addr_a",  64'(l4_addr_a), 64'd0);
        chk("rst_addr_b",  64'(l4_addr_b), 64'd0);
        chk("rst_d_addr",  64'(d4_addr),   64'd0);
        chk("rst_wr_addr", 64'(wr_addr4),  64'd0);
        chk("rst_wr_data", 64'(wr_data4),  64'd0);
        chk("rst2_busy",   64'(busy2),     64'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // Identity
        build_exp(4);
        do_start4();
        #1 chk("busy4_after_start", 64'(busy4), 64'd1);
        wait_done4(300);

        // Diagonal only
        dmem4[0] = 32'h0200_0000; dmem4[1] = 32'h0080_0000;
        dmem4[2] = 32'h0100_0000; dmem4[3] = 32'h0400_0000;
        build_exp(4);
        do_start4();
        wait_done4(300);

        // Coupled N=2 case with hand-derived results
        lmem2[0] = 32'h0; lmem2[1] = 32'h0; lmem2[2] = 32'hFF80_0000; lmem2[3] = 32'h0;
        dmem2[0] = 32'h0100_0000; dmem2[1] = 32'h0200_0000;
        push2(0, 32'h0180_0000);
        push2(1, 32'hFF00_0000);
        push2(2, 32'hFF00_0000);
        push2(3, 32'h0200_0000);
        do_start2();
        wait_done2(100);

        // Garbage in diagonal and upper triangle of Linv
        for (int x = 0; x < 4; x++) dmem4[x] = ONE;
        set_ident4(1'b1);
        build_exp(4);
        do_start4();
        wait_done4(300);

        // Second start while busy must be ignored
        build_exp(4);
        do_start4();
        repeat (9) @(posedge clk);
        #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        wait_done4(300);
        repeat (40) @(posedge clk);
        chk("busy4_idle_after_ignored_start", 64'(busy4), 64'd0);

        // Mid-run reset, then a full clean run
        build_exp(4);
        do_start4();
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        q4.delete(); dq4.delete();
        #1 chk("midrst_busy", 64'(busy4), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        build_exp(4);
        do_start4();
        wait_done4(300);

        // Randomized lower triangles; diagonal/upper filled with garbage
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    lmem4[r*4+c] = rnd_val(t == 3);
            for (int x = 0; x < 4; x++) dmem4[x] = rnd_val(t == 3);
            build_exp(4);
            do_start4();
            wait_done4(300);
        end
        for (int t = 0; t < 3; t++) begin
            for (int x = 0; x < 4; x++) lmem2[x] = rnd_val(t == 2);
            for (int x = 0; x < 2; x++) dmem2[x] = rnd_val(t == 2);
            build_exp(2);
            do_start2();
            wait_done2(100);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldl_inv_combine.md
# ldl_inv_combine

Final stage of the LDL-based covariance inversion in the Kalman update path. It takes the unit-lower-triangular inverse Linv (written in place by the L-inversion stage) and the reciprocal diagonal Dinv. It computes the symmetric inverse Ainv = Linvᵀ · Dinv · Linv in Q-format fixed point and writes the full N×N result, both triangles, into a result RAM. It is started by the upstream stage's `done` and signals completion to the Kalman gain stage.

## Interface
- N, 4: matrix order.
- Q, 24: fractional bits of every stored value.
- WIDTH, 32: data width, two's complement.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- l_addr_a  out  clog2(N*N)  Linv read port A address (k*N+i).
- l_addr_b  out  clog2(N*N)  Linv read port B address (k*N+j).
- l_data_a  in  WIDTH  Linv port A data; valid 1 cycle after the address.
- l_data_b  in  WIDTH  Linv port B data; valid 1 cycle after the address.
- d_addr  out  clog2(N)  Dinv read address (k).
- d_data  in  WIDTH  Dinv data; valid 1 cycle after the address.
- wr_en  out  1  result RAM write strobe.
- wr_addr  out  clog2(N*N)  result address, row*N+col.
- wr_data  out  WIDTH  result data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

## Operation
- Storage: element (r,c) is at address r*N+c. The block uses Linv only for r>c, reads it as 1.0 (1<<Q) for r==c regardless of RAM content, and never reads it for r<c.
- Loop order:
  - Outer i = 0..N-1; inner j = i..N-1.
  - Per pair, k = j..N-1: term(k) = Linv[k][i] · Dinv[k] · Linv[k][j].
  - If k==i, the port A operand is forced to 1<<Q. If k==j, the port B operand is forced to 1<<Q.
- Arithmetic:
  - p1 = sext(a)·sext(dinv), 2·WIDTH bits, arithmetic shift right by Q, truncated to WIDTH.
  - p2 = p1·b, 2·WIDTH bits, sign-extended and added to an accumulator of 2·WIDTH+clog2(N) bits.
  - Result = acc >>> Q (arithmetic, floor toward −inf), truncated to WIDTH. No saturation.
- States:
  - IDLE: on start go to INIT.
  - INIT: acc←0, k←j.
  - ISSUE: drive the three read addresses.
  - WAIT: RAM latency cycle.
  - MUL1: register p1 and the b operand.
  - MUL2: acc += p2. If k<N−1, k++ and go to ISSUE; otherwise go to WR_U.
  - WR_U: write (i,j).
  - WR_L: write (j,i); this state is skipped when i==j.
  - NEXT: if j<N−1, j++; else if i<N−1, i++ and j←i+1… (j←i of the new i). Then INIT, or DONE after the last pair.
  - DONE: pulse done, return to IDLE.
- The read addresses hold their values in all states other than ISSUE.
- start is ignored while busy. Inputs from the Linv and Dinv RAMs are ignored outside MUL1 and MUL2.

## Timing
- Reset values: state IDLE, all indices 0, acc 0; wr_en, done and busy 0; every address output 0; wr_data 0.
- Reset asserted mid-run aborts immediately: no further writes and no done pulse. The next start restarts from (0,0).
- Cycles per pair = 3 + 4·(N−j) + (i≠j ? 1 : 0). The total for N=4 is 116 cycles.
- Done timing: start is sampled at edge E. Then done is high for exactly one cycle, registered at edge E+117 for N=4.
- wr_en lasts exactly one cycle per write. wr_addr and wr_data are valid in the same cycle as wr_en.
- The two writes of an off-diagonal pair are back-to-back, upper first.
- Total writes = N²; each address is written exactly once.
- busy falls in the same cycle done rises.

## Test plan
- Identity: N=4, Linv=I, Dinv all 0x01000000 → 16 writes; diagonal 0x01000000, off-diagonal 0; done at E+117.
- Diagonal only: N=4, Linv=I, Dinv=(2,0.5,1,4)=(0x02000000,0x00800000,0x01000000,0x04000000) → Ainv diagonal equals Dinv, off-diagonal 0.
- Coupled case: N=2, Linv[1][0]=0xFF800000 (−0.5), Dinv=(0x01000000,0x02000000) → writes in this order, with done at E+27:
  - (0,0)=0x01800000
  - (0,1)=0xFF000000
  - (1,0)=0xFF000000
  - (1,1)=0x02000000
- Garbage immunity: repeat the N=4 identity case with 0xDEADBEEF in every Linv diagonal and upper-triangle word → results unchanged.
- Start while busy: a second start pulse is issued 10 cycles after the first → ignored; exactly 16 writes and one done.
- Mid-run reset: rst is asserted at cycle 50, then released, then start is issued → no writes during reset, and a complete, correct 16-write sequence follows.
